pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter and instruction-fetch sequencer for the RAT MCU on Basys3. Drives the 10-bit address into the 1024x18 synchronous program ROM, tracks the ROM's one-cycle read latency, and handles jump, call, return and interrupt redirection. It keeps an internal hardware return-address stack so CALL/RET need no scratch-RAM traffic. Commands come from the control unit.

## Interface
- ADDR_W, 10: program address width (ROM depth 2^ADDR_W).
- STK_DEPTH, 8: return-stack entries (power of two, 2..16).
- RESET_VEC, 10'h000: PC value after reset.
- INTR_VEC, 10'h3FF: PC value loaded on interrupt.

Ports:
- CLK  in  1  single system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- PC_INC  in  1  advance PC by one.
- PC_JMP  in  1  load PC from FROM_IMMED.
- PC_CALL  in  1  push return address, load PC from FROM_IMMED.
- PC_RET  in  1  pop return stack into PC (used for RET and RETIE).
- PC_INTR  in  1  push current PC, load INTR_VEC.
- FROM_IMMED  in  ADDR_W  branch/call target.
- PROG_ADDR  out  ADDR_W  registered PC; connects to ROM address.
- IR_VALID  out  1  ROM output this cycle is the instruction at PROG_ADDR.
- STK_CNT  out  $clog2(STK_DEPTH)+1  current stack occupancy.
- STK_OVF  out  1  sticky: push attempted while full.
- STK_UNF  out  1  sticky: pop attempted while empty.

## Operation
- Reset values: PROG_ADDR=RESET_VEC, IR_VALID=0, STK_CNT=0, STK_OVF=0, STK_UNF=0; stack contents don't-care.
- One command per cycle; if several asserted, priority PC_INTR > PC_RET > PC_CALL > PC_JMP > PC_INC. Lower ones ignored entirely (no push/pop side effects).
- No command asserted: PC holds.
- INC: PC <= PC+1, modulo 2^ADDR_W (3FF -> 000).
- JMP: PC <= FROM_IMMED.
- CALL: push PC+1 (mod 2^ADDR_W); PC <= FROM_IMMED.
- INTR: push PC (the not-yet-executed instruction); PC <= INTR_VEC.
- RET: PC <= top of stack; pop.
- Stack full on CALL/INTR: PC redirect still happens, push dropped, contents and STK_CNT unchanged, STK_OVF <= 1.
- Stack empty on RET: PC <= PC+1 (behaves as INC), STK_CNT stays 0, STK_UNF <= 1.
- STK_OVF/STK_UNF clear only on RST.
- Stack is LIFO indexed by STK_CNT; top = entry STK_CNT-1.
- IR_VALID <= 1 when PC did not change this cycle (no command, or JMP/RET to the same value), else 0. Held 0 during RST.
- RST asserted mid-operation overrides all commands in that cycle.

## Timing
- PROG_ADDR changes on the clock edge where the command is sampled; zero-cycle command-to-address latency beyond that register.
- ROM output for the new address is available one edge later; IR_VALID rises on that edge if no further command.
- Minimum fetch: command at edge N, PROG_ADDR new after N, IR_VALID=1 after N+1 (given no command at N+1).
- Back-to-back INC every cycle: IR_VALID stays 0 (ROM always one address behind).
- Push/pop and STK_CNT update on the same edge as the PC update.
- No combinational path from inputs to outputs.

## Test plan
- Reset then PC_INC for 3 cycles -> PROG_ADDR 000,001,002,003; IR_VALID 0 throughout; one idle cycle later IR_VALID=1.
- PROG_ADDR=3FF (via JMP FROM_IMMED=3FF), then PC_INC -> PROG_ADDR=000; CALL at 3FF with FROM_IMMED=010 -> pushes 000, RET returns to 000.
- At PC=020 CALL 100, at 100 CALL 200, RET, RET -> PC sequence 100, 200, 101, 021; STK_CNT 1,2,1,0.
- 8 CALLs from PC=005 each to FROM_IMMED=005, 9th CALL -> STK_OVF=1, STK_CNT=8, PC=005; 8 RETs all return 006; 9th RET -> PC=007, STK_UNF=1.
- PC_INTR and PC_JMP together at PC=042 -> PC=3FF, stack top=042, STK_CNT=1; subsequent PC_RET -> PC=042.
- RST asserted in the same cycle as PC_CALL at PC=050 with 3 entries stacked -> PROG_ADDR=000, STK_CNT=0, flags 0, IR_VALID=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter and fetch sequencer for the RAT MCU.
// Holds the registered ROM address, flags when the synchronous ROM output
// matches that address, and keeps a hardware return-address stack for
// CALL/RET/interrupt redirection.
module pc_fetch_unit #(
  parameter int                ADDR_W    = 10,
  parameter int                STK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_VEC = 10'h000,
  parameter logic [ADDR_W-1:0] INTR_VEC  = 10'h3FF
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         PC_INC,
  input  logic                         PC_JMP,
  input  logic                         PC_CALL,
  input  logic                         PC_RET,
  input  logic                         PC_INTR,
  input  logic [ADDR_W-1:0]            FROM_IMMED,
  output logic [ADDR_W-1:0]            PROG_ADDR,
  output logic                         IR_VALID,
  output logic [$clog2(STK_DEPTH):0]   STK_CNT,
  output logic                         STK_OVF,
  output logic                         STK_UNF
);

  localparam int                IDX_W    = $clog2(STK_DEPTH);
  localparam int                CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(STK_DEPTH);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] push_val;
  logic [ADDR_W-1:0] stk_top;
  logic [ADDR_W-1:0] stk_mem [STK_DEPTH];
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;
  logic              ovf;
  logic              unf;
  logic              irv;
  logic              push_en;
  logic              pop_en;
  logic              ovf_set;
  logic              unf_set;
  logic              full;
  logic              empty;

  // Wraps modulo 2^ADDR_W naturally through the register width.
  assign pc_plus1 = pc + ADDR_W'(1);
  assign full     = (cnt == CNT_FULL);
  assign empty    = (cnt == '0);
  // Push lands at entry cnt; top of stack is entry cnt-1.
  assign wr_idx   = cnt[IDX_W-1:0];
  assign top_idx  = IDX_W'(cnt - CNT_ONE);
  assign stk_top  = stk_mem[top_idx];

  // Command decode: fixed priority INTR > RET > CALL > JMP > INC; lower
  // commands have no side effects when a higher one is present.
  always_comb begin
    pc_nxt   = pc;
    push_en  = 1'b0;
    pop_en   = 1'b0;
    push_val = pc;
    ovf_set  = 1'b0;
    unf_set  = 1'b0;
    if (PC_INTR) begin
      // Return to the instruction that has not executed yet.
      push_val = pc;
      push_en  = !full;
      ovf_set  = full;
      pc_nxt   = INTR_VEC;
    end else if (PC_RET) begin
      if (empty) begin
        // Underflowing RET degrades to a plain increment.
        unf_set = 1'b1;
        pc_nxt  = pc_plus1;
      end else begin
        pop_en = 1'b1;
        pc_nxt = stk_top;
      end
    end else if (PC_CALL) begin
      push_val = pc_plus1;
      push_en  = !full;
      ovf_set  = full;
      pc_nxt   = FROM_IMMED;
    end else if (PC_JMP) begin
      pc_nxt = FROM_IMMED;
    end else if (PC_INC) begin
      pc_nxt = pc_plus1;
    end
  end

  // Occupancy follows push/pop; a dropped push or refused pop leaves it alone.
  always_comb begin
    cnt_nxt = cnt;
    if (push_en) begin
      cnt_nxt = cnt + CNT_ONE;
    end else if (pop_en) begin
      cnt_nxt = cnt - CNT_ONE;
    end
  end

  // PC, occupancy, sticky error flags and fetch-valid tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc  <= RESET_VEC;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      irv <= 1'b0;
    end else begin
      pc  <= pc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf | ovf_set;
      unf <= unf | unf_set;
      // ROM is one address behind unless the PC stood still this cycle.
      irv <= (pc_nxt == pc);
    end
  end

  // Return-address storage; contents are don't-care after reset.
  always_ff @(posedge CLK) begin
    if (push_en && !RST) begin
      stk_mem[wr_idx] <= push_val;
    end
  end

  assign PROG_ADDR = pc;
  assign IR_VALID  = irv;
  assign STK_CNT   = cnt;
  assign STK_OVF   = ovf;
  assign STK_UNF   = unf;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: each driven cycle pushes the expected
// post-edge state, which is popped and compared one edge later.
module tb_pc_fetch_unit;

  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_INC  = 5'b00001;
  localparam logic [4:0] C_JMP  = 5'b00010;
  localparam logic [4:0] C_CALL = 5'b00100;
  localparam logic [4:0] C_RET  = 5'b01000;
  localparam logic [4:0] C_INTR = 5'b10000;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       PC_INC = 1'b0, PC_JMP = 1'b0, PC_CALL = 1'b0, PC_RET = 1'b0, PC_INTR = 1'b0;
  logic [9:0] FROM_IMMED = '0;
  logic [9:0] PROG_ADDR;
  logic       IR_VALID;
  logic [3:0] STK_CNT;
  logic       STK_OVF;
  logic       STK_UNF;

  pc_fetch_unit dut (
    .CLK(CLK), .RST(RST),
    .PC_INC(PC_INC), .PC_JMP(PC_JMP), .PC_CALL(PC_CALL),
    .PC_RET(PC_RET), .PC_INTR(PC_INTR), .FROM_IMMED(FROM_IMMED),
    .PROG_ADDR(PROG_ADDR), .IR_VALID(IR_VALID), .STK_CNT(STK_CNT),
    .STK_OVF(STK_OVF), .STK_UNF(STK_UNF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [9:0] pc;
    logic       irv;
    logic [3:0] cnt;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t       sbq[$];
  logic [9:0] m_stk[$];
  logic [9:0] m_pc;
  logic       m_ovf, m_unf, m_irv;
  int         n_chk = 0;
  int         n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle, predict its effect, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic [4:0] cmd, input logic [9:0] imm);
    exp_t       e;
    logic [9:0] npc;
    exp_t       got;
    @(negedge CLK);
    RST = rst;
    {PC_INTR, PC_RET, PC_CALL, PC_JMP, PC_INC} = cmd;
    FROM_IMMED = imm;
    if (rst) begin
      m_pc = 10'h000; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_irv = 1'b0;
    end else begin
      npc = m_pc;
      if (cmd[4]) begin
        if (m_stk.size() == 8) m_ovf = 1'b1; else m_stk.push_back(m_pc);
        npc = 10'h3FF;
      end else if (cmd[3]) begin
        if (m_stk.size() == 0) begin m_unf = 1'b1; npc = m_pc + 10'd1; end
        else npc = m_stk.pop_back();
      end else if (cmd[2]) begin
        if (m_stk.size() == 8) m_ovf = 1'b1; else m_stk.push_back(m_pc + 10'd1);
        npc = imm;
      end else if (cmd[1]) npc = imm;
      else if (cmd[0]) npc = m_pc + 10'd1;
      m_irv = (npc == m_pc);
      m_pc  = npc;
    end
    e.tag = tag; e.pc = m_pc; e.irv = m_irv; e.cnt = 4'(m_stk.size());
    e.ovf = m_ovf; e.unf = m_unf;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    got = sbq.pop_front();
    check({got.tag, ".pc"},  32'(PROG_ADDR), 32'(got.pc));
    check({got.tag, ".irv"}, 32'(IR_VALID),  32'(got.irv));
    check({got.tag, ".cnt"}, 32'(STK_CNT),   32'(got.cnt));
    check({got.tag, ".ovf"}, 32'(STK_OVF),   32'(got.ovf));
    check({got.tag, ".unf"}, 32'(STK_UNF),   32'(got.unf));
  endtask

  initial begin
    logic [4:0] rc;
    step("rst0", 1'b1, C_NONE, 10'h000);
    step("rst1", 1'b1, C_INC,  10'h000);
    check("rst_pc", 32'(PROG_ADDR), 32'h000);
    check("rst_irv", 32'(IR_VALID), 32'h0);

    // Sequential fetch then one idle cycle.
    for (int i = 0; i < 3; i++) step("inc", 1'b0, C_INC, 10'h000);
    check("inc3_pc", 32'(PROG_ADDR), 32'h003);
    check("inc3_irv", 32'(IR_VALID), 32'h0);
    step("idle", 1'b0, C_NONE, 10'h000);
    check("idle_irv", 32'(IR_VALID), 32'h1);

    // Wrap-around and CALL at the top of memory.
    step("jmp3ff", 1'b0, C_JMP, 10'h3FF);
    step("wrap", 1'b0, C_INC, 10'h000);
    check("wrap_pc", 32'(PROG_ADDR), 32'h000);
    step("jmp3ff", 1'b0, C_JMP, 10'h3FF);
    step("call010", 1'b0, C_CALL, 10'h010);
    step("ret000", 1'b0, C_RET, 10'h000);
    check("ret_wrap_pc", 32'(PROG_ADDR), 32'h000);

    // Nested calls.
    step("jmp020", 1'b0, C_JMP, 10'h020);
    step("call100", 1'b0, C_CALL, 10'h100);
    step("call200", 1'b0, C_CALL, 10'h200);
    step("ret101", 1'b0, C_RET, 10'h000);
    check("nest_ret1", 32'(PROG_ADDR), 32'h101);
    step("ret021", 1'b0, C_RET, 10'h000);
    check("nest_ret2", 32'(PROG_ADDR), 32'h021);

    // Overflow and underflow.
    step("jmp005", 1'b0, C_JMP, 10'h005);
    for (int i = 0; i < 9; i++) step("callfill", 1'b0, C_CALL, 10'h005);
    check("ovf_flag", 32'(STK_OVF), 32'h1);
    check("ovf_cnt", 32'(STK_CNT), 32'h8);
    for (int i = 0; i < 8; i++) step("retdrain", 1'b0, C_RET, 10'h000);
    check("drain_pc", 32'(PROG_ADDR), 32'h006);
    step("retunf", 1'b0, C_RET, 10'h000);
    check("unf_pc", 32'(PROG_ADDR), 32'h007);
    check("unf_flag", 32'(STK_UNF), 32'h1);

    // Interrupt beats a simultaneous jump.
    step("rst2", 1'b1, C_NONE, 10'h000);
    step("jmp042", 1'b0, C_JMP, 10'h042);
    step("intr", 1'b0, C_INTR | C_JMP, 10'h123);
    check("intr_pc", 32'(PROG_ADDR), 32'h3FF);
    check("intr_cnt", 32'(STK_CNT), 32'h1);
    step("reti", 1'b0, C_RET, 10'h000);
    check("reti_pc", 32'(PROG_ADDR), 32'h042);

    // Priority among RET, CALL and INC with one entry stacked.
    step("call_p", 1'b0, C_CALL, 10'h0A0);
    step("ret_prio", 1'b0, C_RET | C_CALL | C_INC, 10'h155);
    step("call_jmp", 1'b0, C_CALL | C_JMP | C_INC, 10'h155);

    // Reset overrides a CALL with entries stacked.
    step("jmp050", 1'b0, C_JMP, 10'h050);
    for (int i = 0; i < 3; i++) step("call050", 1'b0, C_CALL, 10'h050);
    step("rst_call", 1'b1, C_CALL, 10'h060);
    check("rstc_pc", 32'(PROG_ADDR), 32'h000);
    check("rstc_cnt", 32'(STK_CNT), 32'h0);

    // Random command mix against the model.
    for (int i = 0; i < 300; i++) begin
      rc = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) rc = rc & {1'b0, 4'($urandom)};
      step("rand", ($urandom_range(0, 99) == 0), rc, 10'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
